// File: rtl/fpu_pkg.sv
// Shared types for the FP-add job requester: FSM states, exception code and
// the queued job record.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RETURN,
    DRAIN
  } state_t;

  localparam logic [2:0] EXC_TIMEOUT = 3'b111;

  // Wide enough for a DEPTH of 16; narrower configurations use the low bits.
  localparam int MAX_TAG_W = 5;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic [2:0]           mode;
    logic [MAX_TAG_W-1:0] tag;
  } job_t;

  localparam int JOB_W = $bits(job_t);

endpackage

// File: rtl/fp_job_fifo.sv
// Job queue: DEPTH-entry FIFO with a combinational head and an occupancy count.
// Push and pop may coincide at any occupancy; a push when full is dropped.
module fp_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count_q != '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fp_add_requester.sv
// Queues FP-add jobs and feeds them one at a time to an adder controller,
// returning each result (or a timeout record) through a pop handshake.
module fp_add_requester
  import fpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   Job_valid,
  output logic                   Job_ready,
  input  logic [31:0]            Job_a,
  input  logic [31:0]            Job_b,
  input  logic [2:0]             Job_mode,
  output logic [31:0]            Datain1,
  output logic [31:0]            Datain2,
  output logic                   Data_valid,
  output logic [2:0]             Mode,
  output logic [4:0]             Debug,
  input  logic [31:0]            Dataout,
  input  logic                   Dataout_valid,
  input  logic [2:0]             Exc,
  output logic                   Res_valid,
  input  logic                   Res_ready,
  output logic [31:0]            Res_data,
  output logic [2:0]             Res_exc,
  output logic [$clog2(DEPTH):0] Res_tag,
  output logic                   Res_timeout,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Busy
);

  localparam int TAG_W = $clog2(DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic             dv_q, dv_d;
  logic [31:0]      d1_q, d1_d, d2_q, d2_d;
  logic [2:0]       mode_q, mode_d;
  logic             rv_q, rv_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       rexc_q, rexc_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             rto_q, rto_d;

  job_t push_job, head_job;
  logic push, pop, fifo_full;
  logic unused_tag;

  assign Job_ready = !fifo_full;
  assign push      = Job_valid && Job_ready;
  assign push_job  = '{a: Job_a, b: Job_b, mode: Job_mode, tag: MAX_TAG_W'(tag_cnt_q)};
  assign tag_cnt_d = push ? tag_cnt_q + TAG_W'(1) : tag_cnt_q;
  assign unused_tag = ^head_job.tag;

  fp_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (JOB_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTn),
    .push      (push),
    .push_data (push_job),
    .pop       (pop),
    .head      (head_job),
    .count     (Count),
    .full      (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    cur_tag_d = cur_tag_q;
    dv_d      = dv_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    mode_d    = mode_q;
    rv_d      = rv_q;
    rdata_d   = rdata_q;
    rexc_d    = rexc_q;
    rtag_d    = rtag_q;
    rto_d     = rto_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        // A lingering Dataout_valid from the previous job holds off the next issue.
        if (Count != '0 && !Dataout_valid) begin
          pop       = 1'b1;
          d1_d      = head_job.a;
          d2_d      = head_job.b;
          mode_d    = head_job.mode;
          cur_tag_d = head_job.tag[TAG_W-1:0];
          dv_d      = 1'b1;
          to_cnt_d  = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (Dataout_valid) begin
          dv_d    = 1'b0;
          rdata_d = Dataout;
          rexc_d  = Exc;
          rto_d   = 1'b0;
          rv_d    = 1'b1;
          rtag_d  = cur_tag_q;
          state_d = RETURN;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          dv_d    = 1'b0;
          rdata_d = '0;
          rexc_d  = EXC_TIMEOUT;
          rto_d   = 1'b1;
          rv_d    = 1'b1;
          rtag_d  = cur_tag_q;
          state_d = RETURN;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      RETURN: begin
        if (Res_ready) begin
          rv_d    = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!Dataout_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      tag_cnt_q <= '0;
      cur_tag_q <= '0;
      dv_q      <= 1'b0;
      d1_q      <= '0;
      d2_q      <= '0;
      mode_q    <= '0;
      rv_q      <= 1'b0;
      rdata_q   <= '0;
      rexc_q    <= '0;
      rtag_q    <= '0;
      rto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      tag_cnt_q <= tag_cnt_d;
      cur_tag_q <= cur_tag_d;
      dv_q      <= dv_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      mode_q    <= mode_d;
      rv_q      <= rv_d;
      rdata_q   <= rdata_d;
      rexc_q    <= rexc_d;
      rtag_q    <= rtag_d;
      rto_q     <= rto_d;
    end
  end

  assign Data_valid  = dv_q;
  assign Datain1     = d1_q;
  assign Datain2     = d2_q;
  assign Mode        = mode_q;
  assign Res_valid   = rv_q;
  assign Res_data    = rdata_q;
  assign Res_exc     = rexc_q;
  assign Res_tag     = rtag_q;
  assign Res_timeout = rto_q;
  assign Debug       = '0;
  assign Busy        = (state_q != IDLE) || (Count != '0);

endmodule

// File: doc/fp_add_requester.md
FP_ADD_REQUESTER -- requirements
Module: fp_add_requester

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH, 4, job queue entries (power of two, 2..16).
REQ-003 Parameter TIMEOUT, 255, max cycles waiting for Dataout_valid before abort.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RSTn  in  1  asynchronous active-low reset.
REQ-006 Job_valid / Job_ready  in / out  1 / 1  job push handshake.
REQ-007 Job_a, Job_b  in  32 each  IEEE-754 single operands.
REQ-008 Job_mode  in  3  passed unchanged to Mode.
REQ-009 Datain1, Datain2  out  32 each  operands to the adder controller.
REQ-010 Data_valid  out  1  request to the adder controller.
REQ-011 Mode  out  3; Debug  out  5, constant 0.
REQ-012 Dataout  in  32; Dataout_valid  in  1; Exc  in  3  controller response.
REQ-013 Res_valid / Res_ready  out / in  1 / 1  result pop handshake.
REQ-014 Res_data  out  32; Res_exc  out  3; Res_tag  out  log2(DEPTH)+1 job sequence number; Res_timeout  out  1.
REQ-015 Count  out  log2(DEPTH)+1  queue occupancy; Busy  out  1  FSM not IDLE or Count nonzero.

Function
REQ-016 Queue SHALL be a FIFO; push when Job_valid && Job_ready; Job_ready = (Count < DEPTH).
REQ-017 Each pushed job SHALL get tag = 0-based push index, wrapping modulo 2^(log2(DEPTH)+1).
REQ-018 FSM states SHALL be IDLE, ISSUE, RETURN, DRAIN.
REQ-019 IDLE -> ISSUE when Count > 0 and Dataout_valid == 0: pop head; drive Datain1/Datain2/Mode from it and set Data_valid = 1 on the next edge.
REQ-020 In ISSUE, Data_valid and the operands SHALL be held stable until Dataout_valid == 1 is sampled.
REQ-021 When Dataout_valid == 1 is sampled in ISSUE, the block SHALL clear Data_valid, capture Dataout/Exc into Res_data/Res_exc with Res_timeout = 0, set Res_valid = 1, and go to RETURN.
REQ-022 ISSUE SHALL count cycles; if the count reaches TIMEOUT without Dataout_valid, the block SHALL clear Data_valid, set Res_data = 0, Res_exc = 3'b111, Res_timeout = 1, and go to RETURN.
REQ-023 In RETURN, Res_* SHALL be held stable until Res_valid && Res_ready, then -> DRAIN.
REQ-024 DRAIN -> IDLE once Dataout_valid == 0 is sampled (same-cycle 0 allows a one-cycle DRAIN).
REQ-025 Minimum issue-to-issue spacing SHALL be 4 cycles; one job is outstanding at most.
REQ-026 Simultaneous push and pop in one cycle SHALL be allowed at any occupancy below DEPTH, including when full-minus-one; Count changes by net amount.
REQ-027 Push while Count == DEPTH SHALL be ignored (Job_ready = 0); a pop when empty cannot occur.
REQ-028 Dataout_valid asserting in IDLE, RETURN or DRAIN SHALL be ignored except as the DRAIN/IDLE gating condition.

Reset
REQ-029 On RSTn low, asynchronously: FSM = IDLE, Count = 0, pointers = 0, tag counter = 0, timeout counter = 0, Data_valid = 0, Res_valid = 0, Res_timeout = 0, Datain1/Datain2/Res_data = 0, Mode/Res_exc/Res_tag = 0, Debug = 0, Busy = 0.
REQ-030 Reset mid-ISSUE or mid-RETURN SHALL discard the in-flight job and all queued jobs; no result is produced for them.

Structure
REQ-031 A shared package fpu_pkg SHALL hold the FSM state enum, the EXC_TIMEOUT constant (3'b111), and the job record type (a, b, mode, tag).
REQ-032 The queue SHALL be one sub-module, fp_job_fifo, parameterised by DEPTH and width.

Verification
REQ-033 Job 2.75 + 5.5 (0x40300000, 0x40B00000), controller returns 0x41040000 -> Res_data 0x41040000, Res_exc 0, Res_tag 0, Res_timeout 0.
REQ-034 Push -2.75 + 5.5 and 2.75 + -5.5 back-to-back -> results 0x40300000 (tag 0), then 0xC0300000 (tag 1), in order, with Data_valid low for at least one cycle between the two issues.
REQ-035 Push DEPTH+1 jobs with Res_ready = 0 -> Job_ready drops at Count == DEPTH, the extra job is not accepted, and Count never exceeds DEPTH.
REQ-036 Controller never asserts Dataout_valid -> after TIMEOUT cycles: Data_valid = 0, Res_timeout = 1, Res_exc = 3'b111, Res_data = 0.
REQ-037 Hold Res_ready = 0 for 10 cycles in RETURN -> Res_* remain stable and no new Data_valid is asserted.
REQ-038 Assert RSTn low during ISSUE with 3 jobs queued -> Data_valid = 0 and Count = 0 immediately; after release, the next pushed job gets tag 0.
